// File: rtl/fas_serial_ctrl.sv
// Bit-serial add/subtract sequencer around a single fas full adder/subtractor cell.
// Optional signed-overflow output enabled by defining FAS_OVF_EN.

module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);
  logic a_eff;

  // a_ns=1 gives carry (add); a_ns=0 inverts a so cout becomes the borrow
  assign a_eff = a ~^ a_ns;
  assign s     = a ^ b ^ cin;
  assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);
endmodule

module fas_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef FAS_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_d;
  logic             cy_q, cy_d, sub_q, sub_d;
  logic             busy_d, done_d, carry_d;
  logic             cell_s, cell_cout;
`ifdef FAS_OVF_EN
  logic             a_msb_q, a_msb_d, ovf_d;
`endif

  fas u_fas (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (cy_q),
    .a_ns (~sub_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      sub_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
`ifdef FAS_OVF_EN
      a_msb_q <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      sub_q   <= sub_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      carry   <= carry_d;
`ifdef FAS_OVF_EN
      a_msb_q <= a_msb_d;
      ovf     <= ovf_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    sub_d    = sub_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result;
    carry_d  = carry;
`ifdef FAS_OVF_EN
    a_msb_d  = a_msb_q;
    ovf_d    = ovf;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = op_a;
          b_d      = op_b;
          sub_d    = sub;
          cy_d     = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          result_d = '0;
          carry_d  = 1'b0;
`ifdef FAS_OVF_EN
          a_msb_d  = op_a[WIDTH-1];
          ovf_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        busy_d   = 1'b1;
        result_d = {cell_s, result[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cy_d     = cell_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          carry_d = cell_cout;
`ifdef FAS_OVF_EN
          // b_q[0] holds B's MSB on the last bit; cell_s is the result MSB
          ovf_d   = ((a_msb_q == b_q[0]) ^ sub_q) && (cell_s != a_msb_q);
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/fas_serial_ctrl.md
# fas_serial_ctrl

Bit-serial sequencer that drives a single `fas` full adder/subtractor cell to add or subtract two WIDTH-bit operands, one bit per clock, LSB first. It holds the operands in shift registers and keeps the inter-bit carry/borrow in a flop. It presents a start/busy/done handshake to the surrounding datapath. This is the first clocked block around the `fas` cell, trading WIDTH cycles for a single 1-bit arithmetic cell.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request an operation; sampled only in IDLE.
- `sub`  in  1  operation select: 0 = A+B, 1 = A−B; sampled with `start`.
- `op_a`  in  WIDTH  operand A; sampled with `start`.
- `op_b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse; result fields valid.
- `result`  out  WIDTH  A+B or A−B modulo 2^WIDTH; held until the next accepted `start`.
- `carry`  out  1  carry out (add) or borrow out (sub) of the MSB.
- `ovf`  out  1  signed overflow; present only with FAS_OVF_EN.

## Operation
- Internally instantiates exactly one `fas` cell.
- Cell connections: `a` = A shift-reg LSB, `b` = B shift-reg LSB, `cin` = carry flop.
- Cell `a_ns` = ~`sub` latched: `a_ns`=1 adds, `a_ns`=0 subtracts, with `cout` as borrow.
- State machine:
  - IDLE: `start`=1 loads A/B, latches `sub`, clears carry flop, clears bit counter, clears `result`/`carry`/`ovf`, then goes to RUN. `start`=0 stays in IDLE.
  - RUN: each edge shifts the cell `s` into the result MSB (result shifts right), shifts A/B right, stores `cout` into the carry flop, and increments the counter. The edge that processes bit WIDTH−1 goes to DONE.
  - DONE: `done`=1 for exactly one cycle. Next edge goes to IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- `op_a`/`op_b`/`sub` changes after acceptance have no effect.
- `carry` is updated from the final `cout` on the RUN→DONE edge.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `carry`=0, `ovf`=0, internal counter/shift-regs/carry flop = 0.
- `rst` during RUN or DONE aborts the operation: the next cycle is IDLE with all reset values and no `done` pulse.
- `rst` and `start` high on the same edge: reset wins and `start` is dropped.

## Timing
- Edge E0: `start` accepted in IDLE.
- Edges E1..EWIDTH process bits 0..WIDTH−1; `busy`=1 in the cycles after E0 through EWIDTH−1.
- After EWIDTH: `done`=1, `busy`=0; `result`/`carry`/`ovf` are final.
- After EWIDTH+1: back in IDLE, `done`=0, outputs held.
- Latency from `start` sample to `done` high: WIDTH+1 edges.
- Minimum start-to-start spacing: WIDTH+2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `FAS_OVF_EN`.
- Defined:
  - `ovf` port exists, set on the RUN→DONE edge.
  - Add: `ovf` = (A[MSB]==B[MSB]) && (R[MSB]!=A[MSB]).
  - Sub: `ovf` = (A[MSB]!=B[MSB]) && (R[MSB]!=A[MSB]).
  - A[MSB] is held in a flop captured at `start`.
- Not defined: no `ovf` port, no MSB capture flop; all other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Add 0x35+0x4A → `done` exactly 9 edges after `start`; `result`=0x7F, `carry`=0, `ovf`=0.
- Add 0xFF+0x01 → `result`=0x00, `carry`=1, `ovf`=0. Add 0x7F+0x01 → `result`=0x80, `carry`=0, `ovf`=1.
- Sub 0x10−0x20 → `result`=0xF0, `carry`(borrow)=1, `ovf`=0. Sub 0x80−0x01 → `result`=0x7F, `carry`=0, `ovf`=1.
- `start` re-pulsed with 0x01+0x01 at cycle 3 of a 0x35+0x4A run → ignored; single `done` with 0x7F.
- `rst` at cycle 4 of a run → next cycle IDLE, all outputs 0, no `done`. A following 0x02+0x03 → 0x05.
- Back-to-back: `start` held high continuously → operations accepted every 10 cycles; each `done` pulse lasts 1 cycle.
